fp_norm_pack: RTL
=================

Name: fp_norm_pack

Overview:
- Sequential post-add stage of the floating-point ALU. It consumes the raw 25-bit sign-magnitude mantissa sum, the result sign, and the pre-alignment (larger) exponent from the mantissa adder.
- It normalizes the sum iteratively, one shift per clock, then packs an IEEE-754 single-precision word.
- Valid/ready handshakes on both sides; it sits between the mantissa adder and the ALU result register.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Mantissa with hidden bit is MAN_W+1; input sum is MAN_W+2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream operand valid
- in_ready  output  1  block can accept an operand
- sum  input  MAN_W+2  unnormalized mantissa magnitude; bit MAN_W+1 is the carry, bit MAN_W is the hidden-bit position
- new_sign  input  1  result sign
- exp_in  input  EXP_W  biased exponent of the larger operand
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  1+EXP_W+MAN_W  packed {sign, exponent, fraction}
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero

Behaviour:
- Reset (rst_n=0 at posedge):
  - state to IDLE.
  - in_ready=1, out_valid=0, result=0, overflow=0, underflow=0.
  - Any in-flight operation is discarded. Reset mid-NORM or mid-DONE produces no output.
- States: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch sum into m (MAN_W+2 bits), new_sign into s, and exp_in into e. e is an internal EXP_W+2-bit signed register.
  - Go to NORM. in_ready=0 from the next cycle.
- NORM: one decision per cycle, evaluated in this priority order:
  1. m==0: pack {1'b0, 0, 0} (positive zero, sign forced 0); go to DONE.
  2. e==0: flush; pack {s, 0, 0}; underflow=1; go to DONE.
  3. e==all-ones: pack {s, all-ones, 0}; overflow=1; go to DONE.
  4. m[MAN_W+1]==1:
     - m>>=1 with truncation (no rounding; LSB discarded); e+=1.
     - If the new e equals all-ones, the next cycle takes rule 3.
  5. m[MAN_W]==1: pack {s, e[EXP_W-1:0], m[MAN_W-1:0]}; go to DONE.
  6. Otherwise, if e==1: flush as in rule 2, underflow=1, DONE. No denormals are produced.
  7. Otherwise: m<<=1, e-=1; stay in NORM.
- DONE:
  - out_valid=1. result, overflow and underflow are held stable while out_ready=0.
  - On out_ready=1: go to IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - overflow and underflow clear at that handshake.
  - No new operand is accepted in DONE (no overlap).
- Latency: out_valid rises N+2 cycles after the accept cycle, where N is the number of shift cycles. N is 0 or 1 for a right shift; N ≤ MAN_W for left shifts.
- Throughput: one result per N+3 cycles minimum.
- in_valid is ignored outside IDLE. sum, exp_in and new_sign are sampled only at the accept edge.
- out_ready asserted outside DONE has no effect.

Test Plan:
- Carry normalize: sum=0x1800000, exp_in=127, new_sign=0 -> result=0x40400000 (3.0), overflow=0, underflow=0; out_valid exactly 3 cycles after accept.
- Already normal plus backpressure: sum=0x0800000, exp_in=127, new_sign=0; out_ready held low 3 cycles -> result=0x3F800000 stable, out_valid=1, in_ready=0 throughout; out_valid at accept+2, cleared the cycle after out_ready=1.
- Full cancellation shift: sum=0x0000001, exp_in=127, new_sign=1 -> result=0xB4000000; out_valid at accept+25.
- Exact zero: sum=0, new_sign=1, exp_in=100 -> result=0x00000000, underflow=0, overflow=0, latency 2.
- Overflow: sum=0x1000000, exp_in=254, new_sign=0 -> result=0x7F800000, overflow=1.
- Underflow and reset:
  - sum=0x0000100, exp_in=5, new_sign=0 -> result=0x00000000, underflow=1.
  - Separately, assert rst_n=0 during NORM of the sum=0x0000001 case -> out_valid never rises; in_ready=1 the cycle after reset release.

Source files
------------

// File: rtl/fp_norm_pack.sv
// Post-add normalize/pack stage: iteratively normalizes a raw mantissa sum
// one shift per clock and packs an IEEE-754 single-precision result.
module fp_norm_pack #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAN_W+1:0]         sum,
  input  logic                     new_sign,
  input  logic [EXP_W-1:0]         exp_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned SUM_W = MAN_W + 2;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;

  localparam logic signed [E_W-1:0] E_ZERO = E_W'(0);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((2 ** EXP_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [SUM_W-1:0]        r_m;
  logic                    r_s;
  logic signed [E_W-1:0]   r_e;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [RES_W-1:0]        r_result;
  logic                    r_overflow;
  logic                    r_underflow;

  // Zero, flushed and saturated encodings built from the latched sign.
  logic [RES_W-1:0]        w_flush;
  logic [RES_W-1:0]        w_inf;
  logic [RES_W-1:0]        w_norm;

  assign w_flush = {r_s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
  assign w_inf   = {r_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign w_norm  = {r_s, r_e[EXP_W-1:0], r_m[MAN_W-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_s         <= 1'b0;
      r_e         <= E_ZERO;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_m        <= sum;
            r_s        <= new_sign;
            r_e        <= $signed({2'b00, exp_in});
            r_in_ready <= 1'b0;
            r_state    <= NORM;
          end
        end

        // One normalization decision per cycle, in fixed priority order.
        NORM: begin
          if (r_m == '0) begin
            r_result    <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_e == E_ZERO) begin
            r_result    <= w_flush;
            r_underflow <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_e == E_MAX) begin
            r_result    <= w_inf;
            r_overflow  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_m[MAN_W+1]) begin
            r_m <= r_m >> 1;
            r_e <= r_e + E_ONE;
          end else if (r_m[MAN_W]) begin
            r_result    <= w_norm;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_e == E_ONE) begin
            // Shifting further would need a denormal; flush instead.
            r_result    <= w_flush;
            r_underflow <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_m <= r_m << 1;
            r_e <= r_e - E_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
